// File: rtl/spi_responder.sv
// spi_responder: single-clock serial responder in front of a 2^ADDR_WIDTH x DATA_WIDTH register bank.
// Define CAC_SPI_RESPONDER_ERR_CNT_EN to compile in the saturating aborted-frame counter on err_cnt.
module spi_responder #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  csb,
  input  logic                  sdi,
  output logic                  sdo,
  output logic                  wr_valid,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] host_addr,
  output logic [DATA_WIDTH-1:0] host_rd_data,
  input  logic                  host_wr_en,
  input  logic [DATA_WIDTH-1:0] host_wr_data,
  output logic [7:0]            err_cnt
);
  localparam int FRAME_LEN = 1 + ADDR_WIDTH + DATA_WIDTH;
  localparam int CNT_W     = $clog2(FRAME_LEN + 1);
  localparam int DEPTH     = 2 ** ADDR_WIDTH;
  localparam logic [CNT_W-1:0] LAST_ADDR_BIT = CNT_W'(ADDR_WIDTH);
  localparam logic [CNT_W-1:0] LAST_BIT      = CNT_W'(FRAME_LEN - 1);

  typedef enum logic [2:0] {ST_IDLE, ST_HDR, ST_WR, ST_RD, ST_DONE} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  rw_q, rw_d;
  logic                  hold_q, hold_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  sdo_q, sdo_d;
  logic                  wr_valid_q, wr_valid_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [DATA_WIDTH-1:0] wr_data_q, wr_data_d;
  logic [DATA_WIDTH-1:0] bank_q [DEPTH];
  logic [DATA_WIDTH-1:0] bank_d [DEPTH];

  logic                  commit;
  logic [ADDR_WIDTH-1:0] next_addr;
  logic [DATA_WIDTH-1:0] commit_data;
  logic [DATA_WIDTH-1:0] rd_word;

  assign next_addr   = {addr_q[ADDR_WIDTH-2:0], sdi};
  assign commit_data = {shift_q[DATA_WIDTH-2:0], sdi};
  assign rd_word     = bank_q[next_addr];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rw_d    = rw_q;
    hold_d  = hold_q;
    addr_d  = addr_q;
    shift_d = shift_q;
    sdo_d   = 1'b0;
    commit  = 1'b0;
    if (csb) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hold_d  = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!hold_q) begin
            rw_d    = sdi;
            cnt_d   = CNT_W'(1);
            state_d = ST_HDR;
          end
        end
        ST_HDR: begin
          addr_d = next_addr;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_ADDR_BIT) begin
            if (rw_q) begin
              // Snapshot the word now so later bank writes cannot disturb the bits in flight.
              state_d = ST_RD;
              sdo_d   = rd_word[DATA_WIDTH-1];
              shift_d = {rd_word[DATA_WIDTH-2:0], 1'b0};
            end else begin
              state_d = ST_WR;
            end
          end
        end
        ST_WR: begin
          shift_d = commit_data;
          cnt_d   = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            commit  = 1'b1;
            state_d = ST_DONE;
          end
        end
        ST_RD: begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
            state_d = ST_DONE;
          end else begin
            sdo_d   = shift_q[DATA_WIDTH-1];
            shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
          end
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    wr_valid_d = commit;
    wr_addr_d  = commit ? addr_q : wr_addr_q;
    wr_data_d  = commit ? commit_data : wr_data_q;
  end

  // SPI commit is applied last so it overrides a host write to the same entry.
  always_comb begin
    bank_d = bank_q;
    if (host_wr_en) bank_d[host_addr] = host_wr_data;
    if (commit)     bank_d[addr_q]    = commit_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      rw_q       <= 1'b0;
      // A frame interrupted by reset is ignored until csb returns high.
      hold_q     <= ~csb;
      addr_q     <= '0;
      shift_q    <= '0;
      sdo_q      <= 1'b0;
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      bank_q     <= '{default: '0};
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rw_q       <= rw_d;
      hold_q     <= hold_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      sdo_q      <= sdo_d;
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      bank_q     <= bank_d;
    end
  end

  assign sdo          = sdo_q;
  assign wr_valid     = wr_valid_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign host_rd_data = bank_q[host_addr];

`ifdef CAC_SPI_RESPONDER_ERR_CNT_EN
  logic       abort;
  logic [7:0] err_cnt_q, err_cnt_d;

  assign abort = csb && (state_q inside {ST_HDR, ST_WR, ST_RD});

  always_comb begin
    err_cnt_d = err_cnt_q;
    if (abort && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'h00;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: tb/tb_spi_responder.sv
// Bench for spi_responder: frame-level reference model with per-cycle compare, directed cases, random frames.
module tb_spi_responder;
  localparam int AW = 7;
  localparam int DW = 8;
  localparam int N  = 1 + AW + DW;

  logic          clk = 1'b0;
  logic          rst, csb, sdi, sdo, wr_valid, host_wr_en;
  logic [AW-1:0] wr_addr, host_addr;
  logic [DW-1:0] wr_data, host_rd_data, host_wr_data;
  logic [7:0]    err_cnt;

  always #5 clk = ~clk;

  spi_responder #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .csb(csb), .sdi(sdi), .sdo(sdo),
    .wr_valid(wr_valid), .wr_addr(wr_addr), .wr_data(wr_data),
    .host_addr(host_addr), .host_rd_data(host_rd_data),
    .host_wr_en(host_wr_en), .host_wr_data(host_wr_data), .err_cnt(err_cnt)
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the bits of the current frame and acts on whole fields.
  logic [DW-1:0] ref_bank [2**AW];
  bit            frame_bits [N];
  int            nbits = 0;
  bit            ignoring = 1'b0;
  bit            sdo_sched [$];
  logic          exp_sdo, exp_wr_valid;
  logic [AW-1:0] exp_wr_addr;
  logic [DW-1:0] exp_wr_data;
  logic [7:0]    exp_err;
  bit            model_ok = 1'b0;

  function automatic int field(input int lo, input int w);
    int v = 0;
    for (int k = lo; k < lo + w; k++) v = (v << 1) | int'(frame_bits[k]);
    return v;
  endfunction

  always @(posedge clk) begin : model
    int            ca, cd;
    bit            commit;
    logic [DW-1:0] snap;
    commit = 1'b0;
    ca = 0;
    cd = 0;
    if (rst) begin
      foreach (ref_bank[k]) ref_bank[k] = '0;
      nbits = 0;
      ignoring = !csb;
      sdo_sched.delete();
      exp_sdo = 1'b0;
      exp_wr_valid = 1'b0;
      exp_wr_addr = '0;
      exp_wr_data = '0;
      exp_err = 8'h00;
      model_ok = 1'b1;
    end else begin
      if (csb) begin
        if (!ignoring && nbits > 0 && nbits < N) begin
`ifdef CAC_SPI_RESPONDER_ERR_CNT_EN
          if (exp_err != 8'hFF) exp_err = exp_err + 8'd1;
`endif
        end
        nbits = 0;
        ignoring = 1'b0;
        sdo_sched.delete();
      end else if (!ignoring && nbits < N) begin
        frame_bits[nbits] = sdi;
        nbits++;
        if (nbits == 1 + AW && frame_bits[0]) begin
          snap = ref_bank[field(1, AW)];
          for (int k = DW - 1; k >= 0; k--) sdo_sched.push_back(snap[k]);
        end
        if (nbits == N && !frame_bits[0]) begin
          commit = 1'b1;
          ca = field(1, AW);
          cd = field(1 + AW, DW);
        end
      end
      if (host_wr_en && !(commit && int'(host_addr) == ca)) ref_bank[host_addr] = host_wr_data;
      exp_wr_valid = commit;
      if (commit) begin
        ref_bank[ca] = DW'(cd);
        exp_wr_addr = AW'(ca);
        exp_wr_data = DW'(cd);
      end
      exp_sdo = (sdo_sched.size() > 0) ? sdo_sched.pop_front() : 1'b0;
    end
  end

  int            wv_count = 0;
  logic [AW-1:0] last_wa = '0;
  logic [DW-1:0] last_wd = '0;

  always @(negedge clk) begin
    if (model_ok) begin
      chk("sdo", sdo, exp_sdo);
      chk("wr_valid", wr_valid, exp_wr_valid);
      chk("wr_addr", wr_addr, exp_wr_addr);
      chk("wr_data", wr_data, exp_wr_data);
      chk("host_rd_data", host_rd_data, ref_bank[host_addr]);
      chk("err_cnt", err_cnt, exp_err);
      if (wr_valid === 1'b1) begin
        wv_count++;
        last_wa = wr_addr;
        last_wd = wr_data;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Drives len bits with csb low, then one idle cycle. Optional host write during bit hw_bit.
  task automatic frame(input bit rw, input int addr, input int data, input int len,
                       input int hw_bit, input int hw_addr, input int hw_data,
                       output logic [DW-1:0] rx);
    logic [N-1:0] word;
    word = {rw, AW'(addr), DW'(data)};
    rx = '0;
    for (int i = 0; i < len; i++) begin
      csb = 1'b0;
      sdi = (i < N) ? word[N-1-i] : 1'($urandom_range(0, 1));
      host_wr_en = (i == hw_bit);
      if (i == hw_bit) begin
        host_addr = AW'(hw_addr);
        host_wr_data = DW'(hw_data);
      end
      tick();
      if (i >= AW && i < AW + DW) rx = {rx[DW-2:0], sdo};
    end
    csb = 1'b1;
    sdi = 1'b0;
    host_wr_en = 1'b0;
    tick();
  endtask

  task automatic chk_bank(input string name, input int a, input int e);
    tick();
    host_addr = AW'(a);
    #1;
    chk(name, host_rd_data, e);
  endtask

  task automatic host_write(input int a, input int d);
    host_addr = AW'(a);
    host_wr_data = DW'(d);
    host_wr_en = 1'b1;
    tick();
    host_wr_en = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] rx;
    logic [N-1:0]  word;
    int            wv0, len, r;
    rst = 1'b1; csb = 1'b1; sdi = 1'b0;
    host_wr_en = 1'b0; host_addr = '0; host_wr_data = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
    chk_bank("reset_bank", 'h24, 'h00);
    chk("reset_err_cnt", err_cnt, 8'h00);

    wv0 = wv_count;
    frame(1'b0, 'h24, 'hCC, N, -1, 0, 0, rx);
    chk("wr24_pulses", wv_count - wv0, 1);
    chk("wr24_addr", last_wa, 'h24);
    chk("wr24_data", last_wd, 'hCC);
    chk_bank("wr24_bank", 'h24, 'hCC);

    wv0 = wv_count;
    frame(1'b1, 'h24, 'h00, N, -1, 0, 0, rx);
    chk("rd24_data", rx, 'hCC);
    chk("rd24_no_wr", wv_count - wv0, 0);

    host_write('h28, 'h0F);
    frame(1'b1, 'h28, 'h00, N, -1, 0, 0, rx);
    chk("rd28_data", rx, 'h0F);
    frame(1'b1, 'h28, 'h00, N, 10, 'h28, 'hAA, rx);
    chk("rd28_snapshot", rx, 'h0F);
    chk_bank("host28_bank", 'h28, 'hAA);

    wv0 = wv_count;
    frame(1'b0, 'h10, 'hA5, 10, -1, 0, 0, rx);
    chk("abort_no_wr", wv_count - wv0, 0);
    chk_bank("abort_bank", 'h10, 'h00);
`ifdef CAC_SPI_RESPONDER_ERR_CNT_EN
    chk("abort_err_cnt", err_cnt, 8'h01);
`else
    chk("abort_err_cnt", err_cnt, 8'h00);
`endif

    frame(1'b0, 'h05, 'h33, N, N - 1, 'h05, 'h77, rx);
    chk_bank("collide_same", 'h05, 'h33);
    frame(1'b0, 'h05, 'h33, N, N - 1, 'h06, 'h77, rx);
    chk_bank("collide_diff_host", 'h06, 'h77);
    chk_bank("collide_diff_spi", 'h05, 'h33);

    wv0 = wv_count;
    frame(1'b0, 'h30, 'h5A, N + 4, -1, 0, 0, rx);
    chk("long_frame_pulses", wv_count - wv0, 1);
    chk_bank("long_frame_bank", 'h30, 'h5A);

    wv0 = wv_count;
    word = {1'b0, 7'h31, 8'h99};
    for (int i = 0; i < N; i++) begin
      csb = 1'b0;
      sdi = word[N-1-i];
      rst = (i == 10);
      tick();
    end
    rst = 1'b0;
    csb = 1'b1;
    tick();
    chk("rst_frame_no_wr", wv_count - wv0, 0);
    chk_bank("rst_frame_bank", 'h31, 'h00);
    chk_bank("rst_clears_bank", 'h24, 'h00);
    chk("rst_err_cnt", err_cnt, 8'h00);

    repeat (200) begin
      r = $urandom_range(0, 9);
      len = (r == 0) ? $urandom_range(1, N - 1) : (r == 1) ? $urandom_range(N + 1, N + 4) : N;
      word = {1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom)};
      for (int i = 0; i < len; i++) begin
        csb = 1'b0;
        sdi = (i < N) ? word[N-1-i] : 1'($urandom_range(0, 1));
        host_wr_en = ($urandom_range(0, 3) == 0);
        host_addr = AW'($urandom_range(0, 7));
        host_wr_data = DW'($urandom);
        tick();
      end
      repeat ($urandom_range(1, 3)) begin
        csb = 1'b1;
        sdi = 1'b0;
        host_wr_en = ($urandom_range(0, 3) == 0);
        host_addr = AW'($urandom_range(0, 7));
        host_wr_data = DW'($urandom);
        tick();
      end
    end
    host_wr_en = 1'b0;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
